// File: rtl/glyph_plot_ctrl.sv
// Glyph plot controller: loads an 8x16 glyph into the external pixel serialiser,
// then consumes its MSB stream and emits one VGA plot write per pixel of the cell.
module glyph_plot_ctrl #(
  parameter int GLYPH_W  = 8,
  parameter int GLYPH_H  = 16,
  parameter int COLS     = 20,
  parameter int ROWS     = 7,
  parameter int COLOUR_W = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [4:0]          cell_col,
  input  logic [2:0]          cell_row,
  input  logic [COLOUR_W-1:0] fg_colour,
  input  logic [COLOUR_W-1:0] bg_colour,
  input  logic                transparent,
  input  logic                sh_bit,
  output logic                sh_load_n,
  output logic                sh_shift,
  output logic [7:0]          vga_x,
  output logic [6:0]          vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int NPIX = GLYPH_W * GLYPH_H;
  localparam int PX_W = $clog2(NPIX);
  localparam int CW   = $clog2(GLYPH_W);
  localparam logic [4:0]      COLS_L   = 5'(COLS);
  localparam logic [2:0]      ROWS_L   = 3'(ROWS);
  localparam logic [PX_W-1:0] PX_LAST  = PX_W'(NPIX - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLOT,
    S_DONE,
    S_ERR
  } state_t;

  state_t                state_q, state_d;
  logic [PX_W-1:0]       px_q, px_d;
  logic [4:0]            col_q, col_d;
  logic [2:0]            row_q, row_d;
  logic [COLOUR_W-1:0]   fg_q, fg_d, bg_q, bg_d;
  logic                  tr_q, tr_d;
  logic [7:0]            vga_x_q, vga_x_d;
  logic [6:0]            vga_y_q, vga_y_d;
  logic [COLOUR_W-1:0]   vga_colour_q, vga_colour_d;
  logic                  vga_plot_q, vga_plot_d;

  logic [CW-1:0]         px_col;
  logic [PX_W-CW-1:0]    px_row;

  assign px_col = px_q[CW-1:0];
  assign px_row = px_q[PX_W-1:CW];

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      px_q         <= '0;
      col_q        <= '0;
      row_q        <= '0;
      fg_q         <= '0;
      bg_q         <= '0;
      tr_q         <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      px_q         <= px_d;
      col_q        <= col_d;
      row_q        <= row_d;
      fg_q         <= fg_d;
      bg_q         <= bg_d;
      tr_q         <= tr_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    px_d         = px_q;
    col_d        = col_q;
    row_d        = row_q;
    fg_d         = fg_q;
    bg_d         = bg_q;
    tr_d         = tr_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cell_col < COLS_L && cell_row < ROWS_L) begin
            col_d   = cell_col;
            row_d   = cell_row;
            fg_d    = fg_colour;
            bg_d    = bg_colour;
            tr_d    = transparent;
            state_d = S_LOAD;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_LOAD: begin
        px_d    = '0;
        state_d = S_PLOT;
      end
      S_PLOT: begin
        // Pixel px is on sh_bit now; its plot appears one cycle later.
        vga_x_d      = 8'(col_q * GLYPH_W) + 8'(px_col);
        vga_y_d      = 7'(row_q * GLYPH_H) + 7'(px_row);
        vga_colour_d = sh_bit ? fg_q : bg_q;
        vga_plot_d   = sh_bit | ~tr_q;
        px_d         = px_q + 1'b1;
        if (px_q == PX_LAST) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign sh_load_n  = (state_q == S_LOAD);
  assign sh_shift   = (state_q == S_PLOT);
  assign busy       = (state_q == S_LOAD) || (state_q == S_PLOT) || (state_q == S_DONE);
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERR);
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;

endmodule

// File: tb/tb_glyph_plot_ctrl.sv
// Directed bench for glyph_plot_ctrl with a behavioural 128-bit serialiser model.
module tb_glyph_plot_ctrl;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [4:0]   cell_col = '0;
  logic [2:0]   cell_row = '0;
  logic [2:0]   fg_colour = '0;
  logic [2:0]   bg_colour = '0;
  logic         transparent = 1'b0;
  logic         sh_bit;
  logic         sh_load_n, sh_shift, vga_plot, busy, done, err;
  logic [7:0]   vga_x;
  logic [6:0]   vga_y;
  logic [2:0]   vga_colour;

  logic [127:0] glyph_in = '0;
  logic [127:0] sr_q = '0;

  int errors = 0;
  int checks = 0;
  int overlap_n = 0;

  int plot_n, done_n, done_at, busy_low_at, busy_n, err_n, err_at, act_n, load_n;
  int px_x [256];
  int px_y [256];
  int px_c [256];

  glyph_plot_ctrl dut (
    .clock(clock), .reset(reset), .start(start),
    .cell_col(cell_col), .cell_row(cell_row),
    .fg_colour(fg_colour), .bg_colour(bg_colour), .transparent(transparent),
    .sh_bit(sh_bit), .sh_load_n(sh_load_n), .sh_shift(sh_shift),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  // Serialiser: parallel load on sh_load_n, shift left on sh_shift, MSB out.
  always @(posedge clock) begin
    if (sh_load_n)     sr_q <= glyph_in;
    else if (sh_shift) sr_q <= {sr_q[126:0], 1'b0};
  end
  assign sh_bit = sr_q[127];

  always @(negedge clock) if (sh_load_n && sh_shift) overlap_n++;

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end else begin
      $display("ok   %s: %0d", tag, act);
    end
  endtask

  task automatic clear_stats();
    plot_n = 0; done_n = 0; done_at = -1; busy_low_at = -1; busy_n = 0;
    err_n = 0; err_at = -1; act_n = 0; load_n = 0;
  endtask

  // Sample one cycle (k = cycles after the start-sampling edge).
  task automatic sample(input int k);
    if (vga_plot) begin
      if (plot_n < 256) begin
        px_x[plot_n] = int'(vga_x);
        px_y[plot_n] = int'(vga_y);
        px_c[plot_n] = int'(vga_colour);
      end
      plot_n++;
    end
    if (done) begin done_n++; if (done_at < 0) done_at = k; end
    if (busy) busy_n++;
    if (!busy && busy_low_at < 0 && k > 1) busy_low_at = k;
    if (err) begin err_n++; if (err_at < 0) err_at = k; end
    if (sh_load_n || sh_shift || vga_plot) act_n++;
    if (sh_load_n) load_n++;
  endtask

  // Request one cell, then scramble inputs to prove they were latched.
  task automatic draw(input logic [4:0] c, input logic [2:0] r, input logic [2:0] fg,
                      input logic [2:0] bg, input logic tr, input logic [127:0] g,
                      input int ncyc, input int pulse_at);
    @(negedge clock);
    glyph_in = g; cell_col = c; cell_row = r;
    fg_colour = fg; bg_colour = bg; transparent = tr; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    cell_col = ~c; cell_row = ~r; fg_colour = ~fg; bg_colour = ~bg; transparent = ~tr;
    clear_stats();
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clock);
      sample(k);
      start = (k == pulse_at);
    end
    start = 1'b0;
  endtask

  int n, bad, first_load, second_load;
  logic [23:0] outs;

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    #1;
    outs = {sh_load_n, sh_shift, vga_x, vga_y, vga_colour, vga_plot, busy, done, err};
    check_eq("reset_outputs", int'(outs), 0);
    @(negedge clock);
    reset = 1'b1;

    // 2: corner pixels only set
    draw(5'd0, 3'd0, 3'b111, 3'b000, 1'b0, (128'h1 << 127) | 128'h1, 135, 0);
    check_eq("t2_plot_count", plot_n, 128);
    check_eq("t2_first_colour", px_c[0], 7);
    check_eq("t2_first_xy", px_x[0] * 256 + px_y[0], 0);
    check_eq("t2_last_colour", px_c[127], 7);
    check_eq("t2_last_xy", px_x[127] * 256 + px_y[127], 7 * 256 + 15);
    n = 0;
    for (int i = 0; i < 128; i++) if (px_c[i] != 0) n++;
    check_eq("t2_fg_pixels", n, 2);
    bad = 0;
    for (int i = 0; i < 128; i++) if (px_x[i] != i % 8 || px_y[i] != i / 8) bad++;
    check_eq("t2_scan_order_bad", bad, 0);
    check_eq("t2_done_cycle", done_at, 130);
    check_eq("t2_done_count", done_n, 1);
    check_eq("t2_busy_low_cycle", busy_low_at, 131);

    // 3: bottom-right cell, all ones
    draw(5'd19, 3'd6, 3'b101, 3'b010, 1'b0, {128{1'b1}}, 135, 0);
    check_eq("t3_plot_count", plot_n, 128);
    check_eq("t3_first_xy", px_x[0] * 256 + px_y[0], 152 * 256 + 96);
    check_eq("t3_last_xy", px_x[127] * 256 + px_y[127], 159 * 256 + 111);
    n = 0;
    for (int i = 0; i < 128; i++) if (px_c[i] == 5) n++;
    check_eq("t3_fg_pixels", n, 128);

    // 4: transparent, top row set
    draw(5'd0, 3'd0, 3'b011, 3'b100, 1'b1, 128'hFF << 120, 135, 0);
    check_eq("t4_plot_count", plot_n, 8);
    bad = 0;
    for (int i = 0; i < 8; i++) if (px_x[i] != i || px_y[i] != 0 || px_c[i] != 3) bad++;
    check_eq("t4_plots_bad", bad, 0);

    // 5: out-of-range cells
    draw(5'd20, 3'd0, 3'b111, 3'b000, 1'b0, {128{1'b1}}, 6, 0);
    check_eq("t5_col_err_count", err_n, 1);
    check_eq("t5_col_err_cycle", err_at, 1);
    check_eq("t5_col_activity", act_n, 0);
    check_eq("t5_col_busy", busy_n, 0);
    draw(5'd0, 3'd7, 3'b111, 3'b000, 1'b0, {128{1'b1}}, 6, 0);
    check_eq("t5_row_err_count", err_n, 1);
    check_eq("t5_row_activity", act_n, 0);

    // 6a: start pulse while busy ignored
    draw(5'd3, 3'd2, 3'b001, 3'b000, 1'b0, {128{1'b1}}, 140, 50);
    check_eq("t6_pulse_loads", load_n, 1);
    check_eq("t6_pulse_plots", plot_n, 128);
    check_eq("t6_pulse_first_xy", px_x[0] * 256 + px_y[0], 24 * 256 + 32);

    // 6b: start held high -> back-to-back cells every 131 cycles
    @(negedge clock);
    cell_col = 5'd1; cell_row = 3'd1; start = 1'b1;
    first_load = -1; second_load = -1; n = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clock);
      if (sh_load_n) begin
        n++;
        if (first_load < 0) first_load = k;
        else if (second_load < 0) second_load = k;
      end
    end
    start = 1'b0;
    check_eq("t6_held_loads", n, 3);
    check_eq("t6_held_gap", second_load - first_load, 131);
    repeat (150) @(negedge clock);

    // 1: reset mid-PLOT at px=40
    draw(5'd2, 3'd1, 3'b111, 3'b001, 1'b0, {128{1'b1}}, 41, 0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    outs = {sh_load_n, sh_shift, vga_x, vga_y, vga_colour, vga_plot, busy, done, err};
    check_eq("t1_outputs_after_reset", int'(outs), 0);
    @(negedge clock);
    reset = 1'b1;
    clear_stats();
    for (int k = 2; k <= 10; k++) begin
      @(negedge clock);
      sample(k);
    end
    check_eq("t1_no_activity_after_abort", act_n + done_n, 0);
    draw(5'd0, 3'd0, 3'b110, 3'b001, 1'b0, 128'h0, 135, 0);
    check_eq("t1_redraw_plots", plot_n, 128);
    check_eq("t1_redraw_bg", px_c[64], 1);
    check_eq("t1_redraw_done_cycle", done_at, 130);

    check_eq("load_shift_overlap", overlap_n, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
